// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the F/M-stage unified-memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port variable-latency memory between instruction fetch
// and data access, data first, with fetch flush and a hung-access watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              iflush,
  output logic              ivalid,
  output logic [DATA_W-1:0] irdata,
  input  logic              dreq,
  input  logic              dwe,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dwdata,
  input  logic [3:0]        dbe,
  output logic              dvalid,
  output logic [DATA_W-1:0] drdata,
  output logic              stallF,
  output logic              stallM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_t           state;
  logic             drop;
  logic [CNT_W-1:0] wd_cnt;
  logic [CNT_W-1:0] wd_next;
  logic             wd_expire;
  logic             dreq_new;
  logic             ireq_new;
  logic             drop_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A request whose valid is pulsing this cycle is being retired, not re-issued.
  assign dreq_new  = dreq & ~dvalid;
  assign ireq_new  = ireq & ~ivalid & ~iflush;
  assign stallF    = ireq & ~ivalid & ~iflush;
  assign stallM    = dreq & ~dvalid;
  assign wd_next   = sat_inc(wd_cnt);
  assign wd_expire = (TIMEOUT != 0) && (wd_next == TMO);
  assign drop_now  = drop | iflush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      drop      <= 1'b0;
      wd_cnt    <= '0;
      ivalid    <= 1'b0;
      irdata    <= '0;
      dvalid    <= 1'b0;
      drdata    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      bus_err   <= 1'b0;
    end else begin
      ivalid <= 1'b0;
      dvalid <= 1'b0;
      case (state)
        IDLE: begin
          drop   <= 1'b0;
          wd_cnt <= '0;
          if (dreq_new) begin
            mem_req   <= 1'b1;
            mem_we    <= dwe;
            mem_addr  <= daddr;
            mem_wdata <= dwdata;
            mem_be    <= dbe;
            state     <= D_BUSY;
          end else if (ireq_new) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= iaddr;
            mem_be   <= BE_WORD;
            state    <= I_BUSY;
          end
        end
        I_BUSY: begin
          if (iflush) drop <= 1'b1;
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            if (!drop_now) begin
              ivalid <= 1'b1;
              irdata <= mem_rdata;
            end
          end else if (wd_expire) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= IDLE;
            if (!drop_now) begin
              ivalid <= 1'b1;
              irdata <= '0;
            end
          end else begin
            wd_cnt <= wd_next;
          end
        end
        D_BUSY: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            dvalid  <= 1'b1;
            state   <= IDLE;
            if (!mem_we) drdata <= mem_rdata;
          end else if (wd_expire) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            dvalid  <= 1'b1;
            drdata  <= '0;
            state   <= IDLE;
          end else begin
            wd_cnt <= wd_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: queued expectations checked by a monitor.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk;
  logic        reset;
  logic        ireq;
  logic [31:0] iaddr;
  logic        iflush;
  logic        ivalid;
  logic [31:0] irdata;
  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dbe;
  logic        dvalid;
  logic [31:0] drdata;
  logic        stallF;
  logic        stallM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_err;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iaddr(iaddr), .iflush(iflush), .ivalid(ivalid), .irdata(irdata),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .dbe(dbe),
    .dvalid(dvalid), .drdata(drdata), .stallF(stallF), .stallM(stallM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  typedef struct { logic [31:0] data; int cyc; } rsp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } req_t;

  rsp_t iq[$];
  rsp_t dq[$];
  req_t mq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int lat = 1;
  int cur_lat = 0;
  int mcnt = 0;
  int t0;
  logic prev_req = 1'b0;
  rsp_t mr;
  req_t mg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h0000_0013;
      32'h0000_0044: return 32'h0050_0093;
      32'h0000_1000: return 32'hCAFE_F00D;
      32'h0000_0080: return 32'h0010_0073;
      default:       return a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: per-transaction latency latched on the first mem_req cycle; 0 = never ready.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (mcnt == 0) cur_lat = lat;
        mcnt++;
        mem_ready = (cur_lat != 0) && (mcnt == cur_lat);
        mem_rdata = mem_ready ? mem_val(mem_addr) : 32'h0;
      end else begin
        mcnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
      end
    end
  end

  // Monitor: pops expectations as the DUT presents responses and memory grants.
  initial begin
    forever begin
      @(negedge clk);
      if (ivalid) begin
        if (iq.size() == 0) chk("unexpected ivalid", 32'd1, 32'd0);
        else begin
          mr = iq.pop_front();
          chk("irdata", irdata, mr.data);
          chk("ivalid cycle", cyc, mr.cyc);
        end
      end
      if (dvalid) begin
        if (dq.size() == 0) chk("unexpected dvalid", 32'd1, 32'd0);
        else begin
          mr = dq.pop_front();
          chk("drdata", drdata, mr.data);
          chk("dvalid cycle", cyc, mr.cyc);
        end
      end
      if (mem_req && !prev_req) begin
        if (mq.size() == 0) chk("unexpected mem_req", 32'd1, 32'd0);
        else begin
          mg = mq.pop_front();
          chk("mem_we", {31'd0, mem_we}, {31'd0, mg.we});
          chk("mem_addr", mem_addr, mg.addr);
          chk("mem_be", {28'd0, mem_be}, {28'd0, mg.be});
          if (mg.we) chk("mem_wdata", mem_wdata, mg.wdata);
        end
      end
      prev_req = mem_req;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int budget);
    for (int i = 0; i < budget && (ireq || dreq); i++) begin
      step();
      if (dvalid) dreq = 1'b0;
      if (ivalid) ireq = 1'b0;
    end
    if (ireq || dreq) begin
      chk("handshake timeout", 32'd1, 32'd0);
      ireq = 1'b0;
      dreq = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; ireq = 0; iaddr = 0; iflush = 0;
    dreq = 0; dwe = 0; daddr = 0; dwdata = 0; dbe = 0;
    #12;
    chk("reset mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset ivalid", {31'd0, ivalid}, 32'd0);
    chk("reset dvalid", {31'd0, dvalid}, 32'd0);
    chk("reset bus_err", {31'd0, bus_err}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fetch only, single-cycle memory.
    step();
    t0 = cyc; lat = 1;
    ireq = 1'b1; iaddr = 32'h40;
    mq.push_back('{1'b0, 32'h40, 32'h0, 4'hF});
    iq.push_back('{32'h13, t0 + 2});
    #1 chk("fetch stallF c0", {31'd0, stallF}, 32'd1);
    step();
    chk("fetch mem_req c1", {31'd0, mem_req}, 32'd1);
    chk("fetch stallF c1", {31'd0, stallF}, 32'd1);
    step();
    chk("fetch ivalid c2", {31'd0, ivalid}, 32'd1);
    chk("fetch stallF c2", {31'd0, stallF}, 32'd0);
    chk("fetch mem_req c2", {31'd0, mem_req}, 32'd0);
    ireq = 1'b0;

    // Simultaneous fetch and load: data wins.
    step();
    t0 = cyc; lat = 2;
    ireq = 1'b1; iaddr = 32'h44;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h1000; dbe = 4'hF; dwdata = 32'h1111_2222;
    mq.push_back('{1'b0, 32'h1000, 32'h0, 4'hF});
    mq.push_back('{1'b0, 32'h44, 32'h0, 4'hF});
    dq.push_back('{32'hCAFE_F00D, t0 + 3});
    iq.push_back('{32'h0050_0093, t0 + 6});
    #1 chk("simul stallM c0", {31'd0, stallM}, 32'd1);
    run_until_idle(20);

    // Store: byte enables forwarded, drdata left alone.
    step();
    t0 = cyc; lat = 1;
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h2000; dwdata = 32'hDEAD_BEEF; dbe = 4'b0011;
    mq.push_back('{1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011});
    dq.push_back('{32'hCAFE_F00D, t0 + 2});
    run_until_idle(20);
    dwe = 1'b0;
    chk("store drdata kept", drdata, 32'hCAFE_F00D);
    chk("store no bus_err", {31'd0, bus_err}, 32'd0);

    // Flush mid-fetch, memory ready on 4th busy cycle (also the watchdog edge).
    step();
    t0 = cyc; lat = 4;
    ireq = 1'b1; iaddr = 32'h60;
    mq.push_back('{1'b0, 32'h60, 32'h0, 4'hF});
    mq.push_back('{1'b0, 32'h80, 32'h0, 4'hF});
    iq.push_back('{32'h0010_0073, t0 + 7});
    step();
    step();
    iflush = 1'b1; ireq = 1'b0;
    step();
    iflush = 1'b0; ireq = 1'b1; iaddr = 32'h80; lat = 1;
    step();
    step();
    chk("flush ivalid suppressed", {31'd0, ivalid}, 32'd0);
    chk("flush irdata kept", irdata, 32'h0050_0093);
    chk("flush no bus_err", {31'd0, bus_err}, 32'd0);
    run_until_idle(20);

    // Watchdog abort on a load that never completes.
    step();
    t0 = cyc; lat = 0;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h3000; dbe = 4'hF;
    mq.push_back('{1'b0, 32'h3000, 32'h0, 4'hF});
    dq.push_back('{32'h0, t0 + 5});
    for (int k = 1; k <= 4; k++) step();
    chk("tmo mem_req c4", {31'd0, mem_req}, 32'd1);
    chk("tmo bus_err c4", {31'd0, bus_err}, 32'd0);
    step();
    chk("tmo mem_req c5", {31'd0, mem_req}, 32'd0);
    chk("tmo dvalid c5", {31'd0, dvalid}, 32'd1);
    chk("tmo bus_err c5", {31'd0, bus_err}, 32'd1);
    dreq = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("tmo bus_err sticky", {31'd0, bus_err}, 32'd1);

    // Asynchronous reset in the middle of a D_BUSY access.
    step();
    t0 = cyc; lat = 3;
    dreq = 1'b1; daddr = 32'h1000;
    mq.push_back('{1'b0, 32'h1000, 32'h0, 4'hF});
    step();
    step();
    chk("pre-reset mem_req", {31'd0, mem_req}, 32'd1);
    #1 reset = 1'b1; dreq = 1'b0;
    #1;
    chk("areset mem_req", {31'd0, mem_req}, 32'd0);
    chk("areset mem_addr", mem_addr, 32'd0);
    chk("areset mem_be", {28'd0, mem_be}, 32'd0);
    chk("areset bus_err", {31'd0, bus_err}, 32'd0);
    chk("areset drdata", drdata, 32'd0);
    chk("areset irdata", irdata, 32'd0);
    chk("areset state", {30'd0, dut.state}, {30'd0, IDLE});
    @(negedge clk);
    #2 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post-reset dvalid", {31'd0, dvalid}, 32'd0);
      chk("post-reset mem_req", {31'd0, mem_req}, 32'd0);
    end

    chk("iq drained", iq.size(), 32'd0);
    chk("dq drained", dq.size(), 32'd0);
    chk("mq drained", mq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
